// File: rtl/seq_mul_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_pkg
// Purpose  : Shared types and helpers for the seq_mul_wb multiply unit.
//            - state_t     : FSM encoding (IDLE, RUN, WB)
//            - XZR_IDX     : zero-register index; writes to it are suppressed
//            - select_half : picks MUL (low) or UMULH (high) half of a product
// Revision : 1.0  initial release
// ============================================================================
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [4:0] XZR_IDX = 5'd31;

    // Widest supported operand; the helper works on this width and the
    // caller keeps only its own DATA_W low bits.
    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] select_half(
        input logic [2*MAX_W-1:0] acc,
        input logic               high,
        input int                 w
    );
        logic [2*MAX_W-1:0] s;
        s = high ? (acc >> w) : acc;
        return s[MAX_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mul_wb_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul_wb_if
// Purpose  : Request / register-file write-port bundle of the multiply unit.
//   start, op_high, OpA, OpB, Rd, flush : request side (master -> slave)
//   ready, busy, done                   : status (slave -> master)
//   WriteData, WriteRegister, RegWrite  : register file write port
// Revision : 1.0  initial release
// ============================================================================
interface seq_mul_wb_if #(
    parameter int DATA_W = 64
);
    logic              start;
    logic              op_high;
    logic [DATA_W-1:0] OpA;
    logic [DATA_W-1:0] OpB;
    logic [4:0]        Rd;
    logic              flush;
    logic              ready;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] WriteData;
    logic [4:0]        WriteRegister;
    logic              RegWrite;

    modport master (
        output start, op_high, OpA, OpB, Rd, flush,
        input  ready, busy, done, WriteData, WriteRegister, RegWrite
    );

    modport slave (
        input  start, op_high, OpA, OpB, Rd, flush,
        output ready, busy, done, WriteData, WriteRegister, RegWrite
    );
endinterface
`default_nettype wire

// File: rtl/seq_mul_wb_step.sv
`default_nettype none
// ============================================================================
// Module   : mul_step
// Purpose  : Combinational partial-product add. For every set bit i of the
//            multiplier slice, adds (multiplicand << i) into the accumulator.
//   acc             : current 2*DATA_W accumulator
//   multiplicand    : multiplicand already aligned to this step
//   multiplier_bits : BITS_PER_CYCLE low multiplier bits
//   acc_next        : updated accumulator
// Revision : 1.0  initial release
// ============================================================================
module mul_step #(
    parameter int DATA_W         = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  wire logic [2*DATA_W-1:0]       acc,
    input  wire logic [2*DATA_W-1:0]       multiplicand,
    input  wire logic [BITS_PER_CYCLE-1:0] multiplier_bits,
    output logic      [2*DATA_W-1:0]       acc_next
);

    always_comb begin
        acc_next = acc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (multiplier_bits[i]) begin
                acc_next = acc_next + (multiplicand << i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_mul_wb.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul_wb
// Purpose  : Iterative unsigned DATA_W x DATA_W multiplier (MUL / UMULH)
//            feeding the register file write port.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : seq_mul_wb_if.slave (request, status and write port)
// Accept in IDLE, ITER cycles of RUN, one WB cycle that drives the write.
// Revision : 1.0  initial release
// ============================================================================
module seq_mul_wb
    import mul_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input wire logic     clk,
    input wire logic     reset_n,
    seq_mul_wb_if.slave  bus
);

    localparam int ITER  = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [2*DATA_W-1:0]   r_acc;
    logic [2*DATA_W-1:0]   r_mcand;
    logic [2*DATA_W-1:0]   w_acc_next;
    logic [DATA_W-1:0]     r_mplier;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     w_result;
    logic [MAX_W-1:0]      w_sel;
    logic [CNT_W-1:0]      r_count;
    logic [4:0]            r_rd;
    logic [4:0]            r_wreg;
    logic                  r_op_high;
    logic                  r_done;
    logic                  r_regwrite;
    logic                  w_accept;
    logic                  w_last;

    mul_step #(
        .DATA_W         (DATA_W),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc             (r_acc),
        .multiplicand    (r_mcand),
        .multiplier_bits (r_mplier[BITS_PER_CYCLE-1:0]),
        .acc_next        (w_acc_next)
    );

    // The result is taken from the post-step accumulator so the last
    // partial product is included on the RUN->WB edge.
    assign w_sel    = select_half(w_acc_next, r_op_high, DATA_W);
    assign w_result = w_sel[DATA_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = (r_count == LAST_CNT);
        case (r_state)
            IDLE: begin
                w_accept = bus.start && !bus.flush;
                if (w_accept) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (bus.flush) begin
                    w_state_next = IDLE;
                end else if (w_last) begin
                    w_state_next = WB;
                end
            end
            WB:      w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_count    <= '0;
            r_rd       <= XZR_IDX;
            r_op_high  <= 1'b0;
            r_done     <= 1'b0;
            r_regwrite <= 1'b0;
            r_wdata    <= '0;
            r_wreg     <= XZR_IDX;
        end else begin
            r_done     <= 1'b0;
            r_regwrite <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc     <= '0;
                        r_mcand   <= {{DATA_W{1'b0}}, bus.OpA};
                        r_mplier  <= bus.OpB;
                        r_rd      <= bus.Rd;
                        r_op_high <= bus.op_high;
                        r_count   <= '0;
                    end
                end
                RUN: begin
                    if (!bus.flush) begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << BITS_PER_CYCLE;
                        r_mplier <= r_mplier >> BITS_PER_CYCLE;
                        r_count  <= r_count + 1'b1;
                        if (w_last) begin
                            r_done     <= 1'b1;
                            r_regwrite <= (r_rd != XZR_IDX);
                            r_wdata    <= w_result;
                            r_wreg     <= r_rd;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready         = (r_state == IDLE);
    assign bus.busy          = (r_state == RUN) || (r_state == WB);
    assign bus.done          = r_done;
    assign bus.RegWrite      = r_regwrite;
    assign bus.WriteData     = r_wdata;
    assign bus.WriteRegister = r_wreg;

endmodule
`default_nettype wire
